// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters, with a one-deep response register
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_status,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_status,
    output logic         rsp_err
);
    logic last_grant;
    logic grant;
    logic accept;
    logic unsupported;
    always_comb begin
        grant       = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        // rst_n gates the handshake so nothing is offered while reset is held
        accept      = rst_n && (req0_valid || req1_valid) && (!rsp_valid || rsp_ready);
        req0_ready  = accept && !grant;
        req1_ready  = accept && grant;
        alu_a       = !accept ? '0 : grant ? req1_a : req0_a;
        alu_b       = !accept ? '0 : grant ? req1_b : req0_b;
        alu_op      = !accept ? '0 : grant ? req1_op : req0_op;
        unsupported = alu_op[2] && (alu_op[1] || !alu_op[0]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_status <= '0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            rsp_valid  <= 1'b1;
            rsp_id     <= grant;
            rsp_result <= unsupported ? '0 : alu_result;
            rsp_status <= unsupported ? '0 : alu_status;
            rsp_err    <= unsupported;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end
endmodule
